// File: rtl/jtbubl_snd_mailbox_if.sv
// jtbubl_snd_mailbox_if: main CPU and sound side signals of the command/reply mailbox
interface jtbubl_snd_mailbox_if;
    logic       cen;
    logic [7:0] main_dout;
    logic       main_snd_wr;
    logic       main_snd_rd;
    logic       main_rst_wr;
    logic [7:0] reply_dout;
    logic       reply_pend;
    logic [7:0] snd_reply;
    logic       snd_reply_stb;
    logic       snd_latch_rd;
    logic       snd_nmi_en;
    logic [7:0] snd_latch;
    logic       snd_pend;
    logic       snd_nmi_n;
    logic       snd_rstn;

    // Driver side: the CPUs and the clock-enable source
    modport master (
        output cen, main_dout, main_snd_wr, main_snd_rd, main_rst_wr,
        output snd_reply, snd_reply_stb, snd_latch_rd, snd_nmi_en,
        input  reply_dout, reply_pend, snd_latch, snd_pend, snd_nmi_n, snd_rstn
    );

    // Mailbox side
    modport slave (
        input  cen, main_dout, main_snd_wr, main_snd_rd, main_rst_wr,
        input  snd_reply, snd_reply_stb, snd_latch_rd, snd_nmi_en,
        output reply_dout, reply_pend, snd_latch, snd_pend, snd_nmi_n, snd_rstn
    );
endinterface

// File: rtl/jtbubl_snd_mailbox.sv
// jtbubl_snd_mailbox: main/sound CPU command and reply latches with NMI pulse and sound reset control
module jtbubl_snd_mailbox #(
    parameter int unsigned NMI_LEN = 4
) (
    input logic                  clk,
    input logic                  rst,
    jtbubl_snd_mailbox_if.slave  bus
);
    localparam logic [7:0] LEN = 8'(NMI_LEN);

    typedef enum logic {IDLE, ACTIVE} nmi_state_t;

    logic [4:0] cur, prev, rise;
    logic       wr_e, rd_e, rst_wr_e, latch_rd_e, en_rise;
    logic [7:0] snd_latch, reply_dout, cnt, cnt_nxt;
    logic       snd_pend, reply_pend, hold, snd_rstn, nmi_n, trig;
    nmi_state_t state, state_nxt;

    // snd_nmi_en also needs a history bit so its rising edge can release a deferred NMI
    assign cur        = {bus.snd_nmi_en, bus.snd_latch_rd, bus.main_rst_wr, bus.main_snd_rd, bus.main_snd_wr};
    assign rise       = cur & ~prev;
    assign wr_e       = rise[0];
    assign rd_e       = rise[1];
    assign rst_wr_e   = rise[2];
    assign latch_rd_e = rise[3];
    assign en_rise    = rise[4];
    assign trig       = (wr_e & bus.snd_nmi_en) | (en_rise & snd_pend);

    // Strobe history; cleared on reset so a level already high produces an event afterwards
    always_ff @(posedge clk) begin
        if (rst) prev <= '0;
        else     prev <= cur;
    end

    // Command latch: a write edge beats a simultaneous read edge
    always_ff @(posedge clk) begin
        if (rst) begin
            snd_latch <= '0;
            snd_pend  <= 1'b0;
        end else if (wr_e) begin
            snd_latch <= bus.main_dout;
            snd_pend  <= 1'b1;
        end else if (latch_rd_e) begin
            snd_pend  <= 1'b0;
        end
    end

    // Reply latch: the sound strobe beats a simultaneous main read edge
    always_ff @(posedge clk) begin
        if (rst) begin
            reply_dout <= '0;
            reply_pend <= 1'b0;
        end else if (bus.snd_reply_stb) begin
            reply_dout <= bus.snd_reply;
            reply_pend <= 1'b1;
        end else if (rd_e) begin
            reply_pend <= 1'b0;
        end
    end

    // Sound reset hold bit, with the output line kept low throughout rst
    always_ff @(posedge clk) begin
        if (rst) begin
            hold     <= 1'b0;
            snd_rstn <= 1'b0;
        end else if (rst_wr_e) begin
            hold     <= bus.main_dout[0];
            snd_rstn <= ~bus.main_dout[0];
        end else begin
            snd_rstn <= ~hold;
        end
    end

    // NMI next state: hold forces idle, active pulses are not retriggered
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (hold) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (state == IDLE) begin
            if (trig) begin
                state_nxt = ACTIVE;
                cnt_nxt   = LEN;
            end
        end else if (bus.cen) begin
            cnt_nxt = cnt - 8'd1;
            if (cnt == 8'd1) state_nxt = IDLE;
        end
    end

    // NMI state register; the output is registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            nmi_n <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            nmi_n <= state_nxt != ACTIVE;
        end
    end

    assign bus.snd_latch  = snd_latch;
    assign bus.snd_pend   = snd_pend;
    assign bus.reply_dout = reply_dout;
    assign bus.reply_pend = reply_pend;
    assign bus.snd_nmi_n  = nmi_n;
    assign bus.snd_rstn   = snd_rstn;
endmodule

// File: tb/tb_jtbubl_snd_mailbox.sv
// tb_jtbubl_snd_mailbox: directed and random checks of the mailbox against a cycle-level reference model
module tb_jtbubl_snd_mailbox;
    localparam int NMI_LEN = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    jtbubl_snd_mailbox_if bus();

    jtbubl_snd_mailbox #(.NMI_LEN(NMI_LEN)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ccount = 0;
    bit rand_cen = 1'b0;

    // reference model state: the NMI is just a count of cen ticks still to go
    logic [7:0] m_latch, m_rdout;
    logic       m_pend, m_rpend, m_hold, m_rstn;
    int         m_left;
    logic       p_wr, p_rd, p_rw, p_lr, p_en;

    // pulse monitor
    int  pulses, low_cen;
    logic last_nmi;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic wr_e, rd_e, rw_e, lr_e, en_r, trig;
        if (rst) begin
            m_latch = 0; m_pend = 0; m_rdout = 0; m_rpend = 0;
            m_left = 0; m_hold = 0; m_rstn = 0;
            {p_wr, p_rd, p_rw, p_lr, p_en} = '0;
            return;
        end
        wr_e = bus.main_snd_wr  && !p_wr;
        rd_e = bus.main_snd_rd  && !p_rd;
        rw_e = bus.main_rst_wr  && !p_rw;
        lr_e = bus.snd_latch_rd && !p_lr;
        en_r = bus.snd_nmi_en   && !p_en;
        trig = (wr_e && bus.snd_nmi_en) || (en_r && m_pend);
        if (m_hold) m_left = 0;
        else if (m_left > 0) m_left = m_left - (bus.cen ? 1 : 0);
        else if (trig) m_left = NMI_LEN;
        if (wr_e) begin m_latch = bus.main_dout; m_pend = 1; end
        else if (lr_e) m_pend = 0;
        if (bus.snd_reply_stb) begin m_rdout = bus.snd_reply; m_rpend = 1; end
        else if (rd_e) m_rpend = 0;
        if (rw_e) m_hold = bus.main_dout[0];
        m_rstn = !m_hold;
        p_wr = bus.main_snd_wr; p_rd = bus.main_snd_rd; p_rw = bus.main_rst_wr;
        p_lr = bus.snd_latch_rd; p_en = bus.snd_nmi_en;
    endtask

    task automatic compare_all();
        check("snd_latch",  bus.snd_latch,  m_latch);
        check("snd_pend",   bus.snd_pend,   m_pend);
        check("reply_dout", bus.reply_dout, m_rdout);
        check("reply_pend", bus.reply_pend, m_rpend);
        check("snd_nmi_n",  bus.snd_nmi_n,  m_left == 0);
        check("snd_rstn",   bus.snd_rstn,   m_rstn);
    endtask

    task automatic tick();
        bus.cen = rand_cen ? 1'($urandom_range(0, 1)) : 1'(ccount % 4 == 3);
        ccount++;
        if (bus.snd_nmi_n === 1'b0 && bus.cen) low_cen++;
        model_step();
        @(posedge clk);
        #1;
        compare_all();
        if (last_nmi === 1'b1 && bus.snd_nmi_n === 1'b0) pulses++;
        last_nmi = bus.snd_nmi_n;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clr_mon();
        pulses = 0;
        low_cen = 0;
    endtask

    task automatic pulse_wr(input logic [7:0] d);
        bus.main_dout = d;
        bus.main_snd_wr = 1;
        tick();
        bus.main_snd_wr = 0;
        tick();
    endtask

    initial begin
        bus.cen = 0; bus.main_dout = 0; bus.main_snd_wr = 0; bus.main_snd_rd = 0;
        bus.main_rst_wr = 0; bus.snd_reply = 0; bus.snd_reply_stb = 0;
        bus.snd_latch_rd = 0; bus.snd_nmi_en = 0;
        last_nmi = 1'b1;
        clr_mon();

        // reset state
        rst = 1;
        ticks(2);
        check("rst_latch", bus.snd_latch, 8'h00);
        check("rst_rstn_low", bus.snd_rstn, 1'b0);
        check("rst_nmi_n", bus.snd_nmi_n, 1'b1);
        rst = 0;
        tick();
        check("rstn_after_rst", bus.snd_rstn, 1'b1);

        // command with NMI, write level held 3 cycles
        bus.snd_nmi_en = 1;
        tick();
        clr_mon();
        bus.main_dout = 8'h5A;
        bus.main_snd_wr = 1;
        ticks(3);
        bus.main_snd_wr = 0;
        check("cmd_latch", bus.snd_latch, 8'h5A);
        check("cmd_pend", bus.snd_pend, 1'b1);
        ticks(24);
        check("cmd_nmi_pulses", pulses, 1);
        check("cmd_nmi_cen", low_cen, NMI_LEN);
        check("cmd_nmi_idle", bus.snd_nmi_n, 1'b1);

        // deferred NMI
        bus.snd_nmi_en = 0;
        tick();
        clr_mon();
        pulse_wr(8'h11);
        ticks(8);
        check("defer_no_nmi", pulses, 0);
        bus.snd_nmi_en = 1;
        ticks(24);
        check("defer_nmi_pulses", pulses, 1);
        check("defer_nmi_cen", low_cen, NMI_LEN);
        bus.snd_latch_rd = 1;
        tick();
        bus.snd_latch_rd = 0;
        tick();
        check("defer_pend_clr", bus.snd_pend, 1'b0);

        // overwrite during an active NMI, then write/read collision
        clr_mon();
        pulse_wr(8'h22);
        ticks(3);
        pulse_wr(8'h33);
        check("ovw_latch", bus.snd_latch, 8'h33);
        ticks(24);
        check("ovw_nmi_pulses", pulses, 1);
        check("ovw_nmi_cen", low_cen, NMI_LEN);
        bus.main_dout = 8'h7E;
        bus.main_snd_wr = 1;
        bus.snd_latch_rd = 1;
        tick();
        bus.main_snd_wr = 0;
        bus.snd_latch_rd = 0;
        tick();
        check("coll_pend", bus.snd_pend, 1'b1);
        check("coll_latch", bus.snd_latch, 8'h7E);
        ticks(24);

        // reply path
        bus.snd_reply = 8'hA5;
        bus.snd_reply_stb = 1;
        tick();
        bus.snd_reply_stb = 0;
        check("rep_dout", bus.reply_dout, 8'hA5);
        check("rep_pend", bus.reply_pend, 1'b1);
        bus.main_snd_rd = 1;
        tick();
        bus.main_snd_rd = 0;
        check("rep_clr", bus.reply_pend, 1'b0);
        tick();
        bus.snd_reply = 8'h3C;
        bus.snd_reply_stb = 1;
        bus.main_snd_rd = 1;
        tick();
        bus.snd_reply_stb = 0;
        bus.main_snd_rd = 0;
        check("rep_coll_pend", bus.reply_pend, 1'b1);
        check("rep_coll_dout", bus.reply_dout, 8'h3C);

        // sound reset hold
        bus.main_dout = 8'h01;
        bus.main_rst_wr = 1;
        tick();
        bus.main_rst_wr = 0;
        check("hold_rstn", bus.snd_rstn, 1'b0);
        clr_mon();
        bus.snd_nmi_en = 0;
        tick();
        bus.snd_nmi_en = 1;
        ticks(10);
        check("hold_no_nmi", pulses, 0);
        check("hold_pend", bus.snd_pend, 1'b1);
        bus.main_dout = 8'h00;
        bus.main_rst_wr = 1;
        tick();
        bus.main_rst_wr = 0;
        check("release_rstn", bus.snd_rstn, 1'b1);
        tick();

        // reset in the middle of an NMI pulse
        pulse_wr(8'h66);
        ticks(2);
        check("mid_nmi_low", bus.snd_nmi_n, 1'b0);
        rst = 1;
        tick();
        check("mid_rst_nmi", bus.snd_nmi_n, 1'b1);
        check("mid_rst_latch", bus.snd_latch, 8'h00);
        check("mid_rst_pend", bus.snd_pend, 1'b0);
        check("mid_rst_rstn", bus.snd_rstn, 1'b0);
        rst = 0;
        tick();
        check("mid_after_rstn", bus.snd_rstn, 1'b1);

        // randomized traffic against the model
        rand_cen = 1;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            bus.main_dout = 8'($urandom);
            bus.main_snd_wr = ($urandom_range(0, 3) == 0);
            bus.main_snd_rd = ($urandom_range(0, 3) == 0);
            bus.main_rst_wr = ($urandom_range(0, 39) == 0);
            bus.snd_reply = 8'($urandom);
            bus.snd_reply_stb = ($urandom_range(0, 7) == 0);
            bus.snd_latch_rd = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) bus.snd_nmi_en = ~bus.snd_nmi_en;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
